// File: rtl/memory_access_stage.sv
// MEM stage: drives a req/gnt/rvalid data port, aligns store lanes,
// extends load data and registers the MEM->WB bundle.
// Ports:
//   clk, rst (async, active-high)
//   in_*       : EX->MEM pipe register fields
//   stall      : hold upstream while an access is outstanding
//   dmem_*     : data-memory request/response port
//   out_*      : MEM->WB pipe register fields
module memory_access_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [XLEN-1:0]       in_pc,
  input  logic [XLEN-1:0]       in_irreg_pc,
  input  logic [XLEN-1:0]       in_alu_result,
  input  logic [XLEN-1:0]       in_w_data,
  input  logic [1:0]            in_mem_width,
  input  logic [REG_ADDR_W-1:0] in_rd_addr,
  input  logic                  in_rd_wen,
  input  logic                  in_is_store,
  input  logic                  in_is_load,
  input  logic                  in_is_load_unsigned,
  output logic                  stall,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [XLEN-1:0]       dmem_addr,
  output logic [3:0]            dmem_be,
  output logic [XLEN-1:0]       dmem_wdata,
  input  logic                  dmem_gnt,
  input  logic                  dmem_rvalid,
  input  logic [XLEN-1:0]       dmem_rdata,
  output logic                  out_valid,
  output logic [XLEN-1:0]       out_pc,
  output logic [XLEN-1:0]       out_irreg_pc,
  output logic [XLEN-1:0]       out_r_data,
  output logic [XLEN-1:0]       out_alu_result,
  output logic                  out_is_load,
  output logic                  out_rd_wen,
  output logic [REG_ADDR_W-1:0] out_rd_addr,
  output logic                  out_misaligned
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WGNT = 2'd1;
  localparam logic [1:0] S_WRSP = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [1:0]      off;
  logic            mem_op;
  logic            misal;
  logic            misal_op;
  logic            is_ld;
  logic            done;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_ext;
  logic [XLEN-1:0] r_data_d;

  assign off    = in_alu_result[1:0];
  assign mem_op = in_valid & (in_is_load | in_is_store);
  assign is_ld  = in_is_load;

  always_comb begin
    misal = 1'b0;
    case (in_mem_width)
      2'b00:   misal = 1'b0;
      2'b01:   misal = off[0];
      2'b10:   misal = (off != 2'b00);
      default: misal = 1'b1;
    endcase
  end

  assign misal_op = mem_op & misal;

  // Lane placement of store data and byte enables.
  always_comb begin
    dmem_be    = 4'b0000;
    dmem_wdata = in_w_data;
    case (in_mem_width)
      2'b00: begin
        dmem_be    = 4'b0001 << off;
        dmem_wdata = {4{in_w_data[7:0]}};
      end
      2'b01: begin
        dmem_be    = off[1] ? 4'b1100 : 4'b0011;
        dmem_wdata = {2{in_w_data[15:0]}};
      end
      2'b10: begin
        dmem_be    = 4'b1111;
        dmem_wdata = in_w_data;
      end
      default: begin
        dmem_be    = 4'b0000;
        dmem_wdata = in_w_data;
      end
    endcase
  end

  assign dmem_we   = in_is_store & ~in_is_load;
  assign dmem_addr = {in_alu_result[XLEN-1:2], 2'b00};

  // Load lane extraction and extension.
  assign ld_byte = dmem_rdata[{off, 3'b000} +: 8];
  assign ld_half = off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    ld_ext = dmem_rdata;
    case (in_mem_width)
      2'b00: ld_ext = in_is_load_unsigned
                    ? {{(XLEN-8){1'b0}}, ld_byte}
                    : {{(XLEN-8){ld_byte[7]}}, ld_byte};
      2'b01: ld_ext = in_is_load_unsigned
                    ? {{(XLEN-16){1'b0}}, ld_half}
                    : {{(XLEN-16){ld_half[15]}}, ld_half};
      default: ld_ext = dmem_rdata;
    endcase
  end

  assign r_data_d = (mem_op & is_ld & ~misal) ? ld_ext : '0;

  // Transaction FSM; rvalid is only honoured in S_WRSP.
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!mem_op || misal) begin
          done = 1'b1;
        end else if (dmem_gnt) begin
          if (is_ld) state_d = S_WRSP;
          else       done    = 1'b1;
        end else begin
          state_d = S_WGNT;
        end
      end
      S_WGNT: begin
        if (dmem_gnt) begin
          if (is_ld) begin
            state_d = S_WRSP;
          end else begin
            state_d = S_IDLE;
            done    = 1'b1;
          end
        end
      end
      S_WRSP: begin
        if (dmem_rvalid) begin
          state_d = S_IDLE;
          done    = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        done    = 1'b1;
      end
    endcase
  end

  assign stall    = ~rst & ~done;
  assign dmem_req = ~rst & (((state_q == S_IDLE) & mem_op & ~misal)
                            | (state_q == S_WGNT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid      <= 1'b0;
      out_pc         <= '0;
      out_irreg_pc   <= '0;
      out_r_data     <= '0;
      out_alu_result <= '0;
      out_is_load    <= 1'b0;
      out_rd_wen     <= 1'b0;
      out_rd_addr    <= '0;
      out_misaligned <= 1'b0;
    end else if (stall) begin
      out_valid <= 1'b0;
    end else begin
      out_valid      <= in_valid;
      out_pc         <= in_pc;
      out_irreg_pc   <= in_irreg_pc;
      out_r_data     <= r_data_d;
      out_alu_result <= in_alu_result;
      out_is_load    <= in_is_load;
      out_rd_wen     <= in_rd_wen & ~misal_op;
      out_rd_addr    <= in_rd_addr;
      out_misaligned <= misal_op;
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Testbench for memory_access_stage: directed vector table,
// hand-written reset sequence and random ops against a model.
module tb_memory_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_pc, in_irreg_pc, in_alu_result, in_w_data;
  logic [1:0]  in_mem_width;
  logic [4:0]  in_rd_addr;
  logic        in_rd_wen, in_is_store, in_is_load, in_is_load_unsigned;
  logic        stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        out_valid;
  logic [31:0] out_pc, out_irreg_pc, out_r_data, out_alu_result;
  logic        out_is_load, out_rd_wen, out_misaligned;
  logic [4:0]  out_rd_addr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  memory_access_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_pc(in_pc), .in_irreg_pc(in_irreg_pc),
    .in_alu_result(in_alu_result), .in_w_data(in_w_data),
    .in_mem_width(in_mem_width), .in_rd_addr(in_rd_addr),
    .in_rd_wen(in_rd_wen), .in_is_store(in_is_store),
    .in_is_load(in_is_load),
    .in_is_load_unsigned(in_is_load_unsigned),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .out_valid(out_valid), .out_pc(out_pc),
    .out_irreg_pc(out_irreg_pc), .out_r_data(out_r_data),
    .out_alu_result(out_alu_result), .out_is_load(out_is_load),
    .out_rd_wen(out_rd_wen), .out_rd_addr(out_rd_addr),
    .out_misaligned(out_misaligned)
  );

  typedef struct {
    bit          valid, ld, st, uns, wen;
    logic [1:0]  width;
    logic [31:0] addr, wdata, rdata, pc;
    logic [4:0]  rd;
    int          gdly, rdly;
    bit          rvg;
    int          e_stall;
    bit          e_misal;
    logic [3:0]  e_be;
    logic [31:0] e_wdata, e_rdata;
  } vec_t;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit valid, bit ld, bit st, bit uns,
                              logic [1:0] w, logic [31:0] addr,
                              logic [31:0] wdata, logic [31:0] rdata,
                              int g, int r, bit rvg, int es, bit em,
                              logic [3:0] be, logic [31:0] ew,
                              logic [31:0] er);
    vec_t v;
    v.valid = valid; v.ld = ld; v.st = st; v.uns = uns;
    v.width = w; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.pc = addr + 32'h1000; v.rd = 5'd5; v.wen = 1'b1;
    v.gdly = g; v.rdly = r; v.rvg = rvg;
    v.e_stall = es; v.e_misal = em; v.e_be = be;
    v.e_wdata = ew; v.e_rdata = er;
    return v;
  endfunction

  // Reference model from the access rules, in plain arithmetic.
  function automatic vec_t model(vec_t v);
    int unsigned size, o;
    bit mem;
    logic [31:0] x;
    mem  = v.valid && (v.ld || v.st);
    size = 1 << v.width;
    o    = v.addr % 4;
    v.e_misal = mem && (v.width == 2'd3 || (v.addr % size) != 0);
    if (!mem || v.e_misal) v.e_stall = 0;
    else if (v.ld)         v.e_stall = v.gdly + v.rdly;
    else                   v.e_stall = v.gdly;
    v.e_be = 4'((32'd1 << size) - 1) << o;
    case (v.width)
      2'd0:    v.e_wdata = (v.wdata & 32'hFF) * 32'h0101_0101;
      2'd1:    v.e_wdata = (v.wdata & 32'hFFFF) * 32'h0001_0001;
      default: v.e_wdata = v.wdata;
    endcase
    v.e_rdata = 0;
    if (mem && v.ld && !v.e_misal) begin
      x = v.rdata >> (8 * o);
      if (v.width == 2'd0) begin
        x = x & 32'hFF;
        if (!v.uns && x >= 128) x = x - 256;
      end else if (v.width == 2'd1) begin
        x = x & 32'hFFFF;
        if (!v.uns && x >= 32768) x = x - 65536;
      end else begin
        x = v.rdata;
      end
      v.e_rdata = x;
    end
    return v;
  endfunction

  task automatic idle_inputs();
    in_valid = 0; in_is_load = 0; in_is_store = 0;
    in_is_load_unsigned = 0; in_mem_width = 0;
    in_alu_result = 0; in_w_data = 0; in_pc = 0;
    in_irreg_pc = 0; in_rd_addr = 0; in_rd_wen = 0;
    dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
  endtask

  // Called just after a rising edge; returns just after one.
  task automatic run_op(vec_t v, string tag);
    bit al, ald;
    al  = v.valid && (v.ld || v.st) && !v.e_misal;
    ald = al && v.ld;
    in_valid = v.valid; in_is_load = v.ld; in_is_store = v.st;
    in_is_load_unsigned = v.uns; in_mem_width = v.width;
    in_alu_result = v.addr; in_w_data = v.wdata;
    in_pc = v.pc; in_irreg_pc = ~v.pc;
    in_rd_addr = v.rd; in_rd_wen = v.wen;
    dmem_rdata = v.rdata;
    for (int c = 0; c <= v.e_stall; c++) begin
      dmem_gnt    = al && (c == v.gdly);
      dmem_rvalid = ald && ((c == v.gdly + v.rdly) ||
                            (v.rvg && c == v.gdly));
      @(negedge clk);
      chk({tag, ".stall"}, 32'(stall), 32'(c < v.e_stall));
      chk({tag, ".req"}, 32'(dmem_req), 32'(al && c <= v.gdly));
      if (al && c == 0) begin
        chk({tag, ".addr"}, dmem_addr, v.addr - (v.addr % 4));
        chk({tag, ".be"}, 32'(dmem_be), 32'(v.e_be));
        chk({tag, ".we"}, 32'(dmem_we), 32'(v.st));
        if (v.st) chk({tag, ".wdata"}, dmem_wdata, v.e_wdata);
      end
      @(posedge clk); #1;
      if (c < v.e_stall)
        chk({tag, ".bubble"}, 32'(out_valid), 32'd0);
    end
    dmem_gnt = 0; dmem_rvalid = 0;
    chk({tag, ".ovalid"}, 32'(out_valid), 32'(v.valid));
    chk({tag, ".oalu"}, out_alu_result, v.addr);
    chk({tag, ".opc"}, out_pc, v.pc);
    chk({tag, ".oirq"}, out_irreg_pc, ~v.pc);
    chk({tag, ".ordata"}, out_r_data, v.e_rdata);
    chk({tag, ".omis"}, 32'(out_misaligned), 32'(v.e_misal));
    chk({tag, ".owen"}, 32'(out_rd_wen), 32'(v.wen && !v.e_misal));
    chk({tag, ".ord"}, 32'(out_rd_addr), 32'(v.rd));
    chk({tag, ".old"}, 32'(out_is_load), 32'(v.ld));
  endtask

  vec_t tbl[$];
  vec_t rv;

  initial begin
    idle_inputs();
    rst = 1;
    #12;
    chk("rst.stall", 32'(stall), 0);
    chk("rst.req", 32'(dmem_req), 0);
    chk("rst.ovalid", 32'(out_valid), 0);
    chk("rst.ordata", out_r_data, 0);
    chk("rst.oalu", out_alu_result, 0);
    chk("rst.omis", 32'(out_misaligned), 0);
    @(posedge clk); #1;
    rst = 0;

    // inputs: valid ld st uns w addr wdata rdata g r rvg
    // expected: stall misal be wdata rdata
    tbl.push_back(mk(1,0,0,0,2'd0,32'h1234,0,0,0,1,0,
                     0,0,4'h0,0,0));
    tbl.push_back(mk(1,0,1,0,2'd0,32'h103,32'hAB,0,0,1,0,
                     0,0,4'b1000,32'hABABABAB,0));
    tbl.push_back(mk(1,1,0,0,2'd1,32'h202,0,32'h8001_7FFF,2,2,0,
                     4,0,4'b1100,0,32'hFFFF_8001));
    tbl.push_back(mk(1,1,0,1,2'd1,32'h202,0,32'h8001_7FFF,2,2,0,
                     4,0,4'b1100,0,32'h0000_8001));
    tbl.push_back(mk(1,1,0,0,2'd2,32'h206,0,32'h1111_2222,0,1,0,
                     0,1,4'h0,0,0));
    tbl.push_back(mk(1,1,0,0,2'd0,32'h301,0,32'h0000_F000,0,1,0,
                     1,0,4'b0010,0,32'hFFFF_FFF0));
    tbl.push_back(mk(1,0,0,0,2'd0,32'h5555,0,0,0,1,0,
                     0,0,4'h0,0,0));
    tbl.push_back(mk(1,0,1,0,2'd1,32'h2,32'h1234_BEEF,0,1,1,0,
                     1,0,4'b1100,32'hBEEF_BEEF,0));
    tbl.push_back(mk(1,0,1,0,2'd3,32'h40,32'h1,0,0,1,0,
                     0,1,4'h0,0,0));
    tbl.push_back(mk(1,0,1,0,2'd2,32'h80,32'hCAFE_F00D,0,3,1,0,
                     3,0,4'b1111,32'hCAFE_F00D,0));
    tbl.push_back(mk(1,1,0,1,2'd2,32'h40,0,32'hDEAD_BEEF,1,2,1,
                     3,0,4'b1111,0,32'hDEAD_BEEF));
    tbl.push_back(mk(0,1,0,0,2'd2,32'h44,0,32'h1,0,1,0,
                     0,0,4'h0,0,0));
    tbl.push_back(mk(1,1,0,1,2'd0,32'h303,0,32'h8122_3344,0,1,0,
                     1,0,4'b1000,0,32'h0000_0081));
    foreach (tbl[i]) run_op(tbl[i], $sformatf("v%0d", i));

    // Reset while waiting for the load response.
    rv = mk(1,1,0,0,2'd2,32'h10,0,32'h77,0,1,0,
            1,0,4'b1111,0,32'h77);
    in_valid = 1; in_is_load = 1; in_is_store = 0;
    in_mem_width = 2'd2; in_alu_result = 32'h10;
    in_rd_addr = 5'd7; in_rd_wen = 1;
    dmem_gnt = 1;
    @(negedge clk);
    chk("rr.req0", 32'(dmem_req), 1);
    @(posedge clk); #1;
    dmem_gnt = 0;
    @(negedge clk);
    chk("rr.stall_wrsp", 32'(stall), 1);
    chk("rr.req_wrsp", 32'(dmem_req), 0);
    rst = 1;
    #1;
    chk("rr.stall_rst", 32'(stall), 0);
    chk("rr.req_rst", 32'(dmem_req), 0);
    chk("rr.ovalid_rst", 32'(out_valid), 0);
    @(posedge clk); #1;
    idle_inputs();
    rst = 0;
    dmem_rvalid = 1; dmem_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("rr.stall_late", 32'(stall), 0);
    @(posedge clk); #1;
    dmem_rvalid = 0;
    chk("rr.ovalid_late", 32'(out_valid), 0);
    chk("rr.ordata_late", out_r_data, 0);
    rv = mk(1,0,1,0,2'd2,32'h20,32'h9,0,0,1,0,
            0,0,4'b1111,32'h9,0);
    run_op(rv, "rr.after");

    // Random ops against the model.
    for (int n = 0; n < 300; n++) begin
      int k;
      rv.valid = ($urandom_range(0, 9) != 0);
      k = $urandom_range(0, 2);
      rv.ld = (k == 1); rv.st = (k == 2);
      rv.uns = 1'($urandom_range(0, 1));
      rv.width = 2'($urandom_range(0, 3));
      rv.addr = $urandom;
      if ($urandom_range(0, 3) != 0 && rv.width != 2'd3)
        rv.addr = rv.addr & ~((32'd1 << rv.width) - 1);
      rv.wdata = $urandom; rv.rdata = $urandom; rv.pc = $urandom;
      rv.rd = 5'($urandom); rv.wen = 1'($urandom_range(0, 1));
      rv.gdly = $urandom_range(0, 3);
      rv.rdly = $urandom_range(1, 3);
      rv.rvg = 1'($urandom_range(0, 1));
      rv = model(rv);
      run_op(rv, $sformatf("r%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
